uart_tx_drain: RTL

- Downstream consumer of the CPU-write FIFO fed by the memory-map decoder at address 0xFFFFFFFF.
- Pops words from the FIFO read side and serializes them as 8N1 UART frames on `tx`, LSB first.
- Each word carries WORD_BYTES bytes, sent lowest byte first.
- Sits between the FIFO and the board TX pin; it is the sole reader of the FIFO.

---
 rtl/uart_tx_drain.sv | 159 +++++++++++++++
 1 files changed

// File: rtl/uart_tx_drain.sv
// uart_tx_drain: pops CPU-write FIFO words and sends each byte as an 8N1 frame.
// Define UART_TX_PARITY_EN to insert an even parity bit (8E1, 11-bit frame).

`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module uart_tx_drain #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORD_BYTES   = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [`DATA_WIDTH-1:0] fifo_data_out,
  input  logic                   fifo_empty,
  output logic                   fifo_read_enabled,
  output logic                   tx,
  output logic                   busy
);

  localparam int WW = 8 * WORD_BYTES;
  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] BYTE_LAST = IW'(WORD_BYTES - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    FETCH  = 3'd1,
    START  = 3'd2,
    DATA   = 3'd3,
`ifdef UART_TX_PARITY_EN
    PARITY = 3'd4,
`endif
    STOP   = 3'd5
  } state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [IW-1:0] byte_q, byte_d;
  logic [WW-1:0] word_q, word_d;

  logic       baud_end;
  logic [7:0] cur_byte;
  logic       unused_data;

  // Only the low WW bits of the FIFO word are ever sent.
  assign unused_data = ^fifo_data_out;

  assign baud_end = (baud_q == BAUD_LAST);
  assign cur_byte = word_q[7:0];

  // Pop only from IDLE; gating with rst_n keeps the strobe low in reset.
  assign fifo_read_enabled = rst_n & (state_q == IDLE) & ~fifo_empty;
  assign busy = (state_q != IDLE) | fifo_read_enabled;

  // Line level decoded from state so reset forces idle-high at once.
  always_comb begin
    tx = 1'b1;
    unique case (state_q)
      START:   tx = 1'b0;
      DATA:    tx = cur_byte[bit_q];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx = ^cur_byte;
`endif
      default: tx = 1'b1;
    endcase
  end

  // Next-state, baud timing and byte sequencing.
  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    word_d  = word_q;
    unique case (state_q)
      IDLE: begin
        baud_d = '0;
        if (fifo_read_enabled) state_d = FETCH;
      end
      FETCH: begin
        word_d  = fifo_data_out[WW-1:0];
        byte_d  = '0;
        bit_d   = '0;
        baud_d  = '0;
        state_d = START;
      end
      START: begin
        if (baud_end) begin
          baud_d  = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_d = '0;
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (baud_end) begin
          baud_d  = '0;
          state_d = STOP;
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
`endif
      STOP: begin
        if (baud_end) begin
          baud_d = '0;
          if (byte_q != BYTE_LAST) begin
            byte_d  = byte_q + IW'(1);
            word_d  = word_q >> 8;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          baud_d = baud_q + BW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers; reset aborts any frame in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      word_q  <= '0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      word_q  <= word_d;
    end
  end

endmodule
